// File: rtl/seq1010_sched_pkg.sv
// Shared types and constants for the round-robin "1010" detector scheduler.
// Holds the scheduler and detector state encodings and the match constants.
package seq1010_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_LOAD   = 2'b01,
        S_SHIFT  = 2'b10,
        S_REPORT = 2'b11
    } sched_state_e;

    typedef enum logic [1:0] {
        D_START = 2'b00,
        D_ID1   = 2'b01,
        D_ID10  = 2'b10,
        D_ID101 = 2'b11
    } det_state_e;

    localparam logic FOUND    = 1'b1;
    localparam logic NOTFOUND = 1'b0;

    localparam int ID_W  = 3;
    localparam int CNT_W = 4;

    // Round-robin successor of a requester index among n requesters.
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] idx, input int n);
        if (int'(idx) >= n - 1) begin
            return 3'd0;
        end else begin
            return idx + 3'd1;
        end
    endfunction

endpackage

// File: rtl/seq1010_sched_det.sv
// Overlapping Mealy detector for the serial pattern "1010".
// The synchronous clear returns it to its start state between words.
module det1010_ovl
    import seq1010_sched_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic x_i,
    output logic y_o
);

    det_state_e st_q;
    det_state_e st_d;

    // Detector state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q <= D_START;
        end else begin
            st_q <= st_d;
        end
    end

    // Next-state logic; clear has priority over the input bit.
    always_comb begin
        st_d = D_START;
        if (clr_i) begin
            st_d = D_START;
        end else begin
            case (st_q)
                D_START: st_d = x_i ? D_ID1   : D_START;
                D_ID1:   st_d = x_i ? D_ID1   : D_ID10;
                D_ID10:  st_d = x_i ? D_ID101 : D_START;
                D_ID101: st_d = x_i ? D_ID1   : D_ID10;
                default: st_d = D_START;
            endcase
        end
    end

    // Mealy output: a 0 arriving in id101 completes "1010".
    always_comb begin
        if ((st_q == D_ID101) && !x_i) begin
            y_o = FOUND;
        end else begin
            y_o = NOTFOUND;
        end
    end

endmodule

// File: rtl/seq1010_sched.sv
// Round-robin scheduler sharing one serial "1010" detector among N requesters.
// Each granted word is shifted MSB-first and its match count is reported.
module seq1010_sched
    import seq1010_sched_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req_i,
    input  logic [N*W-1:0]       data_i,
    output logic [N-1:0]         gnt_o,
    output logic                 busy_o,
    output logic                 hit_o,
    output logic                 done_o,
    output logic [ID_W-1:0]      done_id_o,
    output logic [CNT_W-1:0]     match_cnt_o
);

    sched_state_e       state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    cur_id_q, cur_id_d;
    logic [W-1:0]       sr_q, sr_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [N-1:0]       gnt_q, gnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [ID_W-1:0]    done_id_q, done_id_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;

    logic               win_vld_s;
    logic [ID_W-1:0]    win_idx_s;
    logic [W-1:0]       cur_word_s;
    logic               det_clr_s;
    logic               det_x_s;
    logic               det_y_s;
    logic               hit_s;

    det1010_ovl u_det (
        .clk   (clk),
        .reset (reset),
        .clr_i (det_clr_s),
        .x_i   (det_x_s),
        .y_o   (det_y_s)
    );

    assign det_clr_s = (state_q == S_LOAD);
    assign det_x_s   = sr_q[W-1];
    assign hit_s     = (state_q == S_SHIFT) && (det_y_s == FOUND);

    // Round-robin pick: nearest set request at or after ptr, wrapping.
    always_comb begin
        int best_v;
        int dist_v;
        best_v    = N;
        win_idx_s = 3'd0;
        for (int i = 0; i < N; i++) begin
            dist_v = (i - int'(ptr_q) + N) % N;
            if (req_i[i] && (dist_v < best_v)) begin
                best_v    = dist_v;
                win_idx_s = ID_W'(i);
            end else begin
                best_v = best_v;
            end
        end
        win_vld_s = (best_v < N);
    end

    // Word of the requester currently being served.
    always_comb begin
        cur_word_s = '0;
        for (int i = 0; i < N; i++) begin
            if (cur_id_q == ID_W'(i)) begin
                cur_word_s = data_i[i*W +: W];
            end else begin
                cur_word_s = cur_word_s;
            end
        end
    end

    // Scheduler state registers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= 3'd0;
            cur_id_q    <= 3'd0;
            sr_q        <= '0;
            bit_cnt_q   <= 4'd0;
            count_q     <= 4'd0;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= 3'd0;
            match_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cur_id_q    <= cur_id_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            count_q     <= count_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    // Scheduler next-state; grants are issued from IDLE or straight out of REPORT.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cur_id_d    = cur_id_q;
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        count_d     = count_q;
        gnt_d       = '0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        done_id_d   = done_id_q;
        match_cnt_d = match_cnt_q;

        case (state_q)
            S_IDLE, S_REPORT: begin
                if (win_vld_s) begin
                    state_d  = S_LOAD;
                    busy_d   = 1'b1;
                    gnt_d    = {{(N-1){1'b0}}, 1'b1} << win_idx_s;
                    cur_id_d = win_idx_s;
                    ptr_d    = wrap_inc(win_idx_s, N);
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            S_LOAD: begin
                state_d   = S_SHIFT;
                sr_d      = cur_word_s;
                bit_cnt_d = CNT_W'(W - 1);
                count_d   = 4'd0;
            end
            S_SHIFT: begin
                sr_d    = {sr_q[W-2:0], 1'b0};
                count_d = count_q + {3'b000, hit_s};
                // The final bit's hit is folded in as the report values are captured.
                if (bit_cnt_q == 4'd0) begin
                    state_d     = S_REPORT;
                    done_d      = 1'b1;
                    done_id_d   = cur_id_q;
                    match_cnt_d = count_q + {3'b000, hit_s};
                end else begin
                    bit_cnt_d = bit_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign gnt_o       = gnt_q;
    assign busy_o      = busy_q;
    assign hit_o       = hit_s;
    assign done_o      = done_q;
    assign done_id_o   = done_id_q;
    assign match_cnt_o = match_cnt_q;

endmodule

// File: tb/tb_seq1010_sched.sv
// Self-checking bench for seq1010_sched: directed scenarios plus random requests,
// checked every cycle against a word-level reference model.
module tb_seq1010_sched;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int NW = N * W;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic [NW-1:0] data;
    logic [N-1:0]  gnt;
    logic          busy, hit, done;
    logic [2:0]    done_id;
    logic [3:0]    match_cnt;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int            m_phase;      // 0 idle, 1 load, 2..W+1 bit j=phase-2, W+2 report
    int            m_ptr;
    int            m_id;
    logic [W-1:0]  m_word;
    logic [N-1:0]  req_prev;
    int            e_done_id;
    int            e_cnt;
    bit            in_reset;
    bit            hold_all;
    bit            rand_en;
    logic [N-1:0]  pend_mask;
    logic [W-1:0]  pend_word [N];

    always #5 clk = ~clk;

    seq1010_sched #(.N(N), .W(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req),
        .data_i      (data),
        .gnt_o       (gnt),
        .busy_o      (busy),
        .hit_o       (hit),
        .done_o      (done),
        .done_id_o   (done_id),
        .match_cnt_o (match_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Does the bit sequence fed MSB-first end "1010" at bit position j?
    function automatic bit hit_at(input logic [W-1:0] w, input int j);
        logic [W-1:0] t;
        if (j < 3) return 1'b0;
        t = w >> (W - 1 - j);
        return (t[3:0] == 4'b1010);
    endfunction

    function automatic int count1010(input logic [W-1:0] w);
        int c = 0;
        for (int j = 0; j < W; j++) if (hit_at(w, j)) c++;
        return c;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        logic [N-1:0] m;
        for (int k = 0; k < N; k++) begin
            m = N'(1) << ((p + k) % N);
            if ((r & m) != '0) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] word_of(input int i);
        return W'(data >> (i * W));
    endfunction

    task automatic set_word(input int i, input logic [W-1:0] w);
        data = (data & ~(NW'({W{1'b1}}) << (i * W))) | (NW'(w) << (i * W));
    endtask

    // Advance the model one cycle and compare every output.
    task automatic model_step();
        int w;
        logic [N-1:0] eg;
        bit eh;
        if (m_phase == 0 || m_phase == W + 2) begin
            w = rr_pick(req_prev, m_ptr);
            if (w >= 0) begin
                m_phase = 1;
                m_id    = w;
                m_ptr   = (w + 1) % N;
                m_word  = word_of(w);
            end else begin
                m_phase = 0;
            end
        end else begin
            m_phase = m_phase + 1;
        end
        if (m_phase == W + 2) begin
            e_done_id = m_id;
            e_cnt     = count1010(m_word);
        end
        eg = (m_phase == 1) ? (N'(1) << m_id) : '0;
        eh = (m_phase >= 2 && m_phase <= W + 1) ? hit_at(m_word, m_phase - 2) : 1'b0;
        check_eq("gnt", gnt, eg);
        check_eq("gnt_onehot0", $onehot0(gnt), 1);
        check_eq("busy", busy, (m_phase != 0));
        check_eq("hit", hit, eh);
        check_eq("done", done, (m_phase == W + 2));
        check_eq("done_id", done_id, e_done_id);
        check_eq("match_cnt", match_cnt, e_cnt);
        if (m_phase == 1) req = req & ~(N'(1) << m_id);
        req_prev = req;
    endtask

    task automatic drive_slot();
        logic [N-1:0] m;
        logic [W-1:0] w;
        for (int i = 0; i < N; i++) begin
            m = N'(1) << i;
            if (pend_mask[i]) begin
                set_word(i, pend_word[i]);
                req = req | m;
            end else if (rand_en) begin
                if ((req & m) == '0 && $urandom_range(0, 7) == 0) begin
                    case ($urandom_range(0, 3))
                        0:       w = 8'hAA;
                        1:       w = {4'hA, 4'($urandom)};
                        default: w = 8'($urandom);
                    endcase
                    set_word(i, w);
                    req = req | m;
                end else if ((req & m) != '0 && $urandom_range(0, 63) == 0) begin
                    req = req & ~m;
                end
            end
        end
        pend_mask = '0;
        if (hold_all) req = '1;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        drive_slot();
        @(negedge clk);
        if (!in_reset) model_step();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic post(input int i, input logic [W-1:0] w);
        pend_mask[i] = 1'b1;
        pend_word[i] = w;
    endtask

    // Assert reset just after an edge; outputs must clear without waiting for a clock.
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        req   = '0;
        #1;
        check_eq("rst_gnt", gnt, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_hit", hit, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_done_id", done_id, 0);
        check_eq("rst_match_cnt", match_cnt, 0);
        in_reset = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        m_phase   = 0;
        m_ptr     = 0;
        e_done_id = 0;
        e_cnt     = 0;
        req_prev  = '0;
        in_reset  = 1'b0;
        @(negedge clk);
        model_step();
    endtask

    initial begin
        reset     = 1'b0;
        req       = '0;
        data      = '0;
        pend_mask = '0;
        hold_all  = 1'b0;
        rand_en   = 1'b0;
        in_reset  = 1'b1;
        m_phase   = 0;
        m_ptr     = 0;
        m_id      = 0;
        m_word    = '0;
        e_done_id = 0;
        e_cnt     = 0;
        req_prev  = '0;
        do_reset();

        post(0, 8'hAA);
        run(12);
        check_eq("aa_cnt", match_cnt, 3);
        check_eq("aa_id", done_id, 0);

        post(2, 8'h0A);
        run(12);
        check_eq("0a_cnt", match_cnt, 1);
        post(2, 8'hFF);
        run(12);
        check_eq("ff_cnt", match_cnt, 0);

        do_reset();
        post(0, 8'hAA);
        post(2, 8'h0A);
        run(24);
        check_eq("pair_last_id", done_id, 2);
        post(0, 8'h5A);
        post(2, 8'hAA);
        run(24);
        check_eq("pair2_last_id", done_id, 2);
        check_eq("pair2_cnt", match_cnt, 3);

        post(1, 8'h05);
        run(3);
        post(1, 8'h7F);
        run(22);
        check_eq("noxword_cnt", match_cnt, 0);

        post(3, 8'hAA);
        run(5);
        do_reset();
        post(3, 8'hAA);
        run(12);
        check_eq("after_rst_cnt", match_cnt, 3);
        check_eq("after_rst_id", done_id, 3);

        hold_all = 1'b1;
        run(60);
        hold_all = 1'b0;
        run(50);

        rand_en = 1'b1;
        run(3000);
        rand_en = 1'b0;
        req     = '0;
        run(60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq1010_sched.md
# seq1010_sched

Round-robin scheduler that shares one serial "1010" Mealy sequence detector among N requesters. Each requester presents a W-bit word. The scheduler grants one requester at a time, captures its word, and shifts it MSB-first through the detector. It then reports the number of pattern matches found in that word, tagged with the requester index. The block sits between the word-level producers and the bit-serial detector and is the only driver of the detector's input and clear.

## Interface
- N, 4, number of requesters (2..8)
- W, 8, word width in bits (4..16)
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low; clock clk
- req  input  N  request per requester; held high until granted
- data  input  N*W  flattened words; requester i at data[i*W +: W]
- gnt  output  N  one-hot grant, high for exactly one cycle (LOAD)
- busy  output  1  high in LOAD, SHIFT and REPORT
- hit  output  1  Mealy match pulse from detector, gated by SHIFT
- done  output  1  one-cycle pulse in REPORT
- done_id  output  3  index of requester being reported
- match_cnt  output  4  matches in reported word; held until next REPORT

## Operation
- States: IDLE, LOAD, SHIFT, REPORT.
- IDLE: if req != 0, go to LOAD; otherwise stay.
- Arbitration:
  - Round-robin from pointer `ptr`.
  - The winner is the first set req bit at index ptr, ptr+1, … mod N.
  - On grant, ptr <= winner+1 mod N.
  - Arbitration is evaluated in the cycle before LOAD.
- LOAD (1 cycle):
  - gnt[winner]=1.
  - shift register <= data of winner.
  - bit counter <= W-1.
  - detector cleared synchronously to its start state.
  - internal count <= 0.
  - cur_id <= winner.
- SHIFT (W cycles):
  - Detector input x = shift register MSB.
  - Shift register shifts left each cycle; counter decrements.
  - When the detector's Mealy output is 1, hit=1 and the count increments.
  - The last bit is at counter==0, then go to REPORT.
- Detector:
  - States start, id1, id10, id101.
  - start: x=1 -> id1, x=0 -> start.
  - id1: x=1 -> id1, x=0 -> id10.
  - id10: x=1 -> id101, x=0 -> start.
  - id101: x=0 -> id10 with output 1 (overlapping); x=1 -> id1.
  - Output is 0 in all other cases.
- REPORT (1 cycle):
  - done=1.
  - done_id <= cur_id, match_cnt <= count; both registered and held afterwards.
  - If req != 0, go directly to LOAD (arbitrate now); else go to IDLE.
- Requests:
  - A requester dropping req before its grant is simply skipped.
  - req of the currently served requester is ignored until REPORT.
- Cross-word matches: impossible, because the detector is cleared in every LOAD.
- Reset:
  - All state and outputs go to 0: state=IDLE, ptr=0, gnt=0, busy=0, hit=0, done=0, done_id=0, match_cnt=0, detector=start.
  - Reset mid-word aborts it with no done.

## Timing
- req seen high in IDLE at edge k: LOAD during cycle k+1, SHIFT during k+2..k+W+1, REPORT during k+W+2.
- Latency from req to done is W+2 cycles (10 for W=8).
- Back-to-back words: one word every W+2 cycles, with no IDLE between.
- hit is combinational from state and the current bit. It is valid in the same cycle as the bit completing "1010".
- match_cnt updates on the REPORT edge. Maximum value is (W-2)/2, so 4 bits always suffice.

## Structure
- The shared header (`include`) holds:
  - state encodings of the scheduler (2-bit) and detector (2-bit);
  - the FOUND/NOTFOUND constants.
- Sub-module `det1010_ovl`:
  - ports clk, reset, clr, x, y;
  - the overlapping Mealy detector above.
- Everything else is in the top: arbiter, shift register, counters, scheduler FSM.

## Test plan
- Reset, then req=0001 with data0=8'hAA -> gnt=0001 one cycle later; hit pulses on bits 4, 6, 8; done at 10 cycles with done_id=0, match_cnt=3.
- req=0100, data2=8'h0A -> done_id=2, match_cnt=1; data2=8'hFF -> match_cnt=0.
- After reset, req=0101 simultaneously -> requester 0 is served first, then requester 2 back-to-back (done pulses 10 cycles apart). A following req=0101 is again served 0 then 2.
- Word 8'h05 then 8'h7F from the same requester -> match_cnt 0 and 0, proving no carry of "101" across the word boundary.
- Assert reset during SHIFT -> all outputs 0 immediately; no done. A new req after release gives a clean word with the correct count.
- Hold req=1111 continuously -> grant order 0, 1, 2, 3, 0…; busy never drops; gnt is always one-hot.
